rr_packet_arbiter: RTL and testbench
====================================

# rr_packet_arbiter

Round-robin, packet-atomic arbiter that shares one output channel among REQ_NUM requesters with valid/ready handshakes. It picks the next requester with poll_with_start_entry and a one-hot rotating pointer. It then holds the grant until the packet's last beat is accepted. It sits in front of router output ports and shared injection/ejection links, wherever several packet sources contend for one link.

## Interface
- REQ_NUM, 4: number of requesters (≥2).
- DATA_WIDTH, 64: beat width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  REQ_NUM  per-requester beat valid.
- req_last  in  REQ_NUM  per-requester last-beat-of-packet flag.
- req_data  in  REQ_NUM*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  REQ_NUM  per-requester accept; at most one bit set.
- out_valid  out  1  output beat valid.
- out_last  out  1  output last flag.
- out_data  out  DATA_WIDTH  output beat.
- out_ready  in  1  downstream accept.
- grant  out  REQ_NUM  one-hot current owner, or zero.
- busy  out  1  high while in LOCKED.

## Operation
- State: FSM {IDLE, LOCKED}, owner reg (one-hot REQ_NUM), rr_ptr reg (one-hot REQ_NUM).
- Pick: poll_with_start_entry(entry_vec=req_valid, start_entry=rr_ptr) gives pick and found. Search starts at rr_ptr and goes upward, then wraps to bit 0.
- grant = pick in IDLE when found; grant = owner in LOCKED; otherwise 0.
- Output mux is AND-OR over grant:
  - out_valid = |(grant & req_valid).
  - out_last = |(grant & req_last).
  - out_data is the selected slice, and is 0 when grant is 0.
- req_ready = grant & {REQ_NUM{out_ready}}.
- xfer = out_valid & out_ready; last_xfer = xfer & out_last.
- IDLE, found:
  - last_xfer: stay IDLE, rr_ptr <= rotl(pick).
  - xfer without last: go to LOCKED, owner <= pick.
  - No xfer (stall): go to LOCKED, owner <= pick. This freezes the selection so the offered beat stays stable.
- IDLE, not found: no change.
- LOCKED:
  - Only owner is served.
  - On last_xfer: go to IDLE, rr_ptr <= rotl(owner), owner <= 0.
  - If the owner drops req_valid mid-packet, out_valid goes low and the FSM stays LOCKED. There is no re-arbitration and no timeout.
- rotl: bit REQ_NUM-1 wraps to bit 0.
- Requests from non-owners during LOCKED are ignored. They do not affect rr_ptr.

## Timing
- Reset (async assert, immediate): state=IDLE, owner=0, rr_ptr=1 (bit 0). While rst_n is low: out_valid=0, out_last=0, out_data=0, req_ready=0, grant=0, busy=0.
- First arbitration is in the first clk edge window after rst_n deasserts.
- Latency: zero cycles. Request to out_valid, and out_ready to req_ready, are combinational.
- Throughput: one beat per cycle. Back-to-back single-beat packets from different requesters are served with no bubble.
- rr_ptr, owner and state change only on clk edges with a handshake or a stall, as above.
- busy rises the cycle after the lock edge and falls the cycle after last_xfer.
- Simultaneous events: when all requesters are valid with rr_ptr=bit k, requester k wins. In IDLE, a single-beat last_xfer rotates the pointer in the same edge.
- Reset mid-packet: the packet is abandoned and all outputs drop immediately. After release, arbitration restarts from bit 0.

## Structure
- Shared package/header holds:
  - the state encoding: IDLE=1'b0, LOCKED=1'b1;
  - the rotl function, used for the one-hot pointer rotate.
- One sub-module instance: poll_with_start_entry (ENTRIES_NUM=REQ_NUM).
- FSM, registers and output mux are in this block.

## Test plan
- Reset with rst_n=0 and all req_valid=1 -> out_valid=0, grant=0, req_ready=0, busy=0. After release, the first grant=0001.
- All four requesters send single-beat packets, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001. Each accept is in one cycle with no bubbles.
- req0 sends a 3-beat packet while req1 is valid throughout -> grant=0001 for 3 accepts, req_ready[1]=0 during that time, busy=1. Then grant=0010 on the cycle after last.
- Only req2 valid, out_ready=0 for 3 cycles; req0 asserts in cycle 2 -> grant stays 0100 with out_data stable. After last accept, rr_ptr=1000 and the next grant=0001.
- Wrap: after requester 2 is served (rr_ptr=1000), req_valid=1001 -> grant 1000 first, then 0001.
- Assert rst_n low mid-packet (LOCKED, owner=0010) -> outputs drop the same cycle. After release, state=IDLE, rr_ptr=0001, and with req_valid=0010 the grant=0010.

Source files
------------

// File: rtl/rr_packet_arbiter_pkg.sv
// Shared definitions for the round-robin packet arbiter.
//   arb_state_e : FSM encoding (IDLE = no owner, LOCKED = a packet is in flight)
//   MAX_REQ     : widest requester vector the rotl helper handles
//   rotl()      : rotate a one-hot vector left by one inside an n-bit field,
//                 so bit n-1 wraps to bit 0
package rr_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 32;

  // vec must be zero above bit n-1. The mask drops the bit shifted out
  // of the n-bit field; the right shift brings bit n-1 back to bit 0.
  function automatic logic [MAX_REQ-1:0] rotl(input logic [MAX_REQ-1:0] vec,
                                               input int                 n);
    logic [MAX_REQ-1:0] mask;
    mask = (n >= MAX_REQ) ? '1 : ((MAX_REQ'(1) << n) - MAX_REQ'(1));
    return ((vec << 1) | (vec >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/poll_with_start_entry.sv
// Circular priority picker.
// The search starts at the one-hot start entry and moves toward higher
// indices. It then wraps to entry 0.
//   entry_vec_i   [ENTRIES_NUM] : candidate entries
//   start_entry_i [ENTRIES_NUM] : one-hot search start position
//   pick_o        [ENTRIES_NUM] : one-hot winner, zero when nothing is set
//   found_o                     : any entry set
module poll_with_start_entry #(
  parameter int ENTRIES_NUM = 4
) (
  input  logic [ENTRIES_NUM-1:0] entry_vec_i,
  input  logic [ENTRIES_NUM-1:0] start_entry_i,
  output logic [ENTRIES_NUM-1:0] pick_o,
  output logic                   found_o
);

  logic [ENTRIES_NUM-1:0] upper_mask;
  logic [ENTRIES_NUM-1:0] upper_req;

  // upper_mask covers the start bit and everything above it. The search
  // takes the lowest set bit there first, then the lowest set bit overall
  // (the wrap). x & -x isolates the lowest set bit.
  always_comb begin
    upper_mask = ~(start_entry_i - ENTRIES_NUM'(1));
    upper_req  = entry_vec_i & upper_mask;
    if (|upper_req) begin
      pick_o = upper_req & (~upper_req + ENTRIES_NUM'(1));
    end else begin
      pick_o = entry_vec_i & (~entry_vec_i + ENTRIES_NUM'(1));
    end
    found_o = |entry_vec_i;
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-atomic arbiter. It shares one output channel among
// REQ_NUM requesters and holds the grant until the packet's last beat is
// accepted.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/last/data : per-requester beat (requester i occupies
//                         req_data[i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready           : per-requester accept, at most one bit set
//   out_valid/last/data : selected beat toward the shared link
//   out_ready           : downstream accept
//   grant               : one-hot current owner, or zero
//   busy                : high while in LOCKED (the FSM state made visible)
//
// Handshake: a beat moves when valid and ready are both high on a rising
// clk edge. out_valid follows the granted requester's req_valid. Only the
// granted requester sees out_ready on its req_ready. Valid never depends
// on ready.
//
// REQ_NUM must be between 2 and rr_packet_arbiter_pkg::MAX_REQ.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM-1:0]            req_last,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
  output logic [REQ_NUM-1:0]            req_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [REQ_NUM-1:0]            grant,
  output logic                          busy
);

  arb_state_e         state_q, state_d;
  logic [REQ_NUM-1:0] owner_q, owner_d;
  logic [REQ_NUM-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_NUM-1:0] pick;
  logic               found;
  logic               xfer;
  logic               last_xfer;

  poll_with_start_entry #(
    .ENTRIES_NUM(REQ_NUM)
  ) u_poll (
    .entry_vec_i  (req_valid),
    .start_entry_i(rr_ptr_q),
    .pick_o       (pick),
    .found_o      (found)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= REQ_NUM'(1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (last_xfer) begin
            // A single-beat packet finishes in the same cycle it is picked,
            // so there is nothing to lock. Just advance the pointer.
            rr_ptr_d = REQ_NUM'(rotl(MAX_REQ'(pick), REQ_NUM));
          end else begin
            // Lock on a partial transfer and also on a stall. Locking on a
            // stall keeps the offered beat stable even if a higher-priority
            // requester shows up next cycle.
            state_d = LOCKED;
            owner_d = pick;
          end
        end
      end
      LOCKED: begin
        if (last_xfer) begin
          state_d  = IDLE;
          owner_d  = '0;
          rr_ptr_d = REQ_NUM'(rotl(MAX_REQ'(owner_q), REQ_NUM));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    grant = '0;
    // Gate on rst_n so every output drops as soon as reset asserts, even
    // while requesters keep req_valid high.
    if (rst_n) begin
      unique case (state_q)
        IDLE:    grant = found ? pick : '0;
        LOCKED:  grant = owner_q;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        out_data = out_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_valid = |(grant & req_valid);
  assign out_last  = |(grant & req_last);
  assign req_ready = grant & {REQ_NUM{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (REQ_NUM=4, DATA_WIDTH=64).
// The stimulus pushes each expected accepted beat {grant, last, data} into
// exp_q. A monitor on the falling edge pops and compares every beat the
// DUT accepts. Direct checks cover grant, ready, busy and the reset
// behaviour.
module tb_rr_packet_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int EW = N + 1 + W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rr_packet_arbiter #(
    .REQ_NUM   (N),
    .DATA_WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_data (out_data),
    .out_ready(out_ready),
    .grant    (grant),
    .busy     (busy)
  );

  // ---------------- driver helpers ----------------
  function automatic logic [W-1:0] dval(input int i, input int beat);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(beat);
  endfunction

  task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
    req_valid[i]      = v;
    req_last[i]       = l;
    req_data[i*W +: W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [N-1:0] g, input logic l, input logic [W-1:0] d);
    exp_q.push_back({g, l, d});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      mon_got = {grant, out_last, out_data};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got %h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL beat: got grant=%b last=%b data=%h expected grant=%b last=%b data=%h",
                   mon_got[EW-1 -: N], mon_got[W], mon_got[W-1:0],
                   mon_exp[EW-1 -: N], mon_exp[W], mon_exp[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, dval(i, 0));

    // Reset held with every requester valid: all outputs quiet
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_grant",     64'(grant),     64'(4'b0000));
    check("rst_req_ready", 64'(req_ready), 64'(4'b0000));
    check("rst_busy",      64'(busy),      64'(1'b0));
    check("rst_out_data",  out_data,       64'h0);
    tick();
    tick();
    check("rst_grant_hold", 64'(grant), 64'(4'b0000));

    // Single-beat packets from everyone: 0001,0010,0100,1000,... no bubbles
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant",     64'(grant),     64'(4'b0001 << (k % 4)));
      check("rr_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      check("rr_out_valid", 64'(out_valid), 64'(1'b1));
      expect_beat(4'b0001 << (k % 4), 1'b1, dval(k % 4, 0));
      tick();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 64'h0);
    #1;
    check("idle_grant", 64'(grant), 64'(4'b0000));

    // req0 3-beat packet while req1 waits (pointer back at bit 0)
    set_req(0, 1'b1, 1'b0, dval(0, 0));
    set_req(1, 1'b1, 1'b1, dval(1, 0));
    #1;
    check("pkt_b0_grant", 64'(grant), 64'(4'b0001));
    check("pkt_b0_busy",  64'(busy),  64'(1'b0));
    expect_beat(4'b0001, 1'b0, dval(0, 0));
    tick();
    set_req(0, 1'b1, 1'b0, dval(0, 1));
    #1;
    check("pkt_b1_grant", 64'(grant),     64'(4'b0001));
    check("pkt_b1_busy",  64'(busy),      64'(1'b1));
    check("pkt_b1_ready", 64'(req_ready), 64'(4'b0001));
    expect_beat(4'b0001, 1'b0, dval(0, 1));
    tick();
    set_req(0, 1'b1, 1'b1, dval(0, 2));
    #1;
    check("pkt_b2_busy",  64'(busy),      64'(1'b1));
    check("pkt_b2_ready", 64'(req_ready), 64'(4'b0001));
    expect_beat(4'b0001, 1'b1, dval(0, 2));
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0);
    #1;
    check("pkt_next_grant", 64'(grant), 64'(4'b0010));
    check("pkt_next_busy",  64'(busy),  64'(1'b0));
    expect_beat(4'b0010, 1'b1, dval(1, 0));
    tick();
    set_req(1, 1'b0, 1'b0, 64'h0);

    // Stall: only req2, out_ready low for 3 cycles, req0 joins in cycle 2
    out_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, dval(2, 0));
    #1;
    check("stall_c1_grant", 64'(grant),     64'(4'b0100));
    check("stall_c1_valid", 64'(out_valid), 64'(1'b1));
    check("stall_c1_ready", 64'(req_ready), 64'(4'b0000));
    tick();
    set_req(0, 1'b1, 1'b1, dval(0, 3));
    #1;
    check("stall_c2_grant", 64'(grant), 64'(4'b0100));
    check("stall_c2_busy",  64'(busy),  64'(1'b1));
    check("stall_c2_data",  out_data,   dval(2, 0));
    tick();
    #1;
    check("stall_c3_grant", 64'(grant), 64'(4'b0100));
    check("stall_c3_data",  out_data,   dval(2, 0));
    tick();
    out_ready = 1'b1;
    #1;
    check("stall_acc_ready", 64'(req_ready), 64'(4'b0100));
    expect_beat(4'b0100, 1'b1, dval(2, 0));
    tick();
    set_req(2, 1'b0, 1'b0, 64'h0);
    #1;
    check("stall_after_grant", 64'(grant), 64'(4'b0001));
    check("stall_after_busy",  64'(busy),  64'(1'b0));
    expect_beat(4'b0001, 1'b1, dval(0, 3));
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0);

    // Wrap: serve req2 (pointer -> 1000), then 1001 requesting
    set_req(2, 1'b1, 1'b1, dval(2, 1));
    #1;
    check("wrap_req2_grant", 64'(grant), 64'(4'b0100));
    expect_beat(4'b0100, 1'b1, dval(2, 1));
    tick();
    set_req(2, 1'b0, 1'b0, 64'h0);
    set_req(0, 1'b1, 1'b1, dval(0, 4));
    set_req(3, 1'b1, 1'b1, dval(3, 1));
    #1;
    check("wrap_first_grant", 64'(grant), 64'(4'b1000));
    expect_beat(4'b1000, 1'b1, dval(3, 1));
    tick();
    set_req(3, 1'b0, 1'b0, 64'h0);
    #1;
    check("wrap_second_grant", 64'(grant), 64'(4'b0001));
    expect_beat(4'b0001, 1'b1, dval(0, 4));
    tick();
    set_req(0, 1'b0, 1'b0, 64'h0);

    // Reset in the middle of a req1 packet
    set_req(1, 1'b1, 1'b0, dval(1, 1));
    #1;
    check("mid_b0_grant", 64'(grant), 64'(4'b0010));
    expect_beat(4'b0010, 1'b0, dval(1, 1));
    tick();
    set_req(1, 1'b1, 1'b0, dval(1, 2));
    #1;
    check("mid_locked_busy", 64'(busy), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(1'b0));
    check("mid_rst_grant", 64'(grant),     64'(4'b0000));
    check("mid_rst_ready", 64'(req_ready), 64'(4'b0000));
    check("mid_rst_busy",  64'(busy),      64'(1'b0));
    check("mid_rst_data",  out_data,       64'h0);
    tick();
    tick();
    set_req(1, 1'b1, 1'b1, dval(1, 3));
    rst_n = 1'b1;
    #1;
    check("post_rst_busy",  64'(busy),  64'(1'b0));
    check("post_rst_grant", 64'(grant), 64'(4'b0010));
    expect_beat(4'b0010, 1'b1, dval(1, 3));
    tick();
    set_req(1, 1'b0, 1'b0, 64'h0);
    #1;
    check("end_grant", 64'(grant), 64'(4'b0000));
    tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
